// File: rtl/fifo_uart_tx.sv
// Drains a synchronous FIFO one word at a time and serialises each word as a
// UART frame: start bit (0), DATA_WIDTH data bits LSB first, stop bit (1).
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_WIDTH + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, LATCH, START, DATA, STOP} state_t;

  state_t                  state_q, state_d;
  logic [BAUD_W-1:0]       baud_q, baud_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    tx_q, tx_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    baud_last;

  // The pop request is the only combinational output; reset masks it at once.
  assign fifo_rd_en = (state_q == IDLE) && !rst && tx_enable && !fifo_empty;
  assign baud_last  = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (fifo_rd_en) state_d = LATCH;
      end
      LATCH: begin
        shift_d = fifo_data;
        baud_d  = '0;
        state_d = START;
      end
      START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) state_d = STOP;
          else                   bit_d   = bit_q + 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        baud_d  = '0;
        bit_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are derived from the next state so the registered line lines up
  // with the state the FSM is actually in.
  always_comb begin
    tx_d = 1'b1;
    if (state_d == START)     tx_d = 1'b0;
    else if (state_d == DATA) tx_d = shift_d[0];
    busy_d = (state_d != IDLE);
    done_d = (state_d == STOP) && (baud_d == BAUD_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (8b/4clk and 5b/2clk) fed by a bench FIFO,
// checked every cycle against a frame-timeline model derived from UART framing.
module tb_fifo_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic tx_enable = 1'b0;
  logic chk_on = 1'b0;

  logic [7:0] fmem [2][0:255];
  logic [7:0] fdata [2] = '{8'h00, 8'h00};
  int fwr [2] = '{0, 0};
  int frd [2] = '{0, 0};
  int mrd [2] = '{0, 0};
  int pops [2] = '{0, 0};
  int dones [2] = '{0, 0};

  int phase [2] = '{0, 0};
  logic [7:0] mword [2];
  logic [7:0] rxw [2];
  int n_chk = 0;
  int n_err = 0;

  wire e0 = (frd[0] >= fwr[0]);
  wire e1 = (frd[1] >= fwr[1]);
  wire rd0, rd1, tx0, tx1, busy0, busy1, done0, done1;

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) dut0 (
    .clk(clk), .rst(rst), .tx_enable(tx_enable), .fifo_empty(e0),
    .fifo_data(fdata[0]), .fifo_rd_en(rd0), .tx(tx0), .busy(busy0),
    .frame_done(done0)
  );

  fifo_uart_tx #(.DATA_WIDTH(5), .CLKS_PER_BIT(2)) dut1 (
    .clk(clk), .rst(rst), .tx_enable(tx_enable), .fifo_empty(e1),
    .fifo_data(fdata[1][4:0]), .fifo_rd_en(rd1), .tx(tx1), .busy(busy1),
    .frame_done(done1)
  );

  // Bench FIFO: data_out updates on the rd_en edge.
  always @(posedge clk) begin
    if (rd0 && frd[0] < fwr[0]) begin
      fdata[0] <= fmem[0][frd[0]];
      frd[0]   <= frd[0] + 1;
    end
    if (rd1 && frd[1] < fwr[1]) begin
      fdata[1] <= fmem[1][frd[1]];
      frd[1]   <= frd[1] + 1;
    end
    if (rd0)   pops[0]  <= pops[0] + 1;
    if (rd1)   pops[1]  <= pops[1] + 1;
    if (done0) dones[0] <= dones[0] + 1;
    if (done1) dones[1] <= dones[1] + 1;
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int w_of(int i);
    return (i == 0) ? 8 : 5;
  endfunction

  function automatic int c_of(int i);
    return (i == 0) ? 4 : 2;
  endfunction

  // Model: phase = clks since the pop cycle (0 = idle). Phase 1 is the latch
  // cycle, then (W+2)*C clks of frame; bit b of the frame is start/data/stop.
  task automatic model_step(int i);
    int w, c, p, k, b;
    logic exp_rd, exp_tx, exp_busy, exp_done;
    logic got_rd, got_tx, got_busy, got_done;
    w = w_of(i);
    c = c_of(i);
    p = phase[i];
    got_rd   = (i == 0) ? rd0   : rd1;
    got_tx   = (i == 0) ? tx0   : tx1;
    got_busy = (i == 0) ? busy0 : busy1;
    got_done = (i == 0) ? done0 : done1;
    exp_rd   = 1'b0;
    exp_tx   = 1'b1;
    exp_busy = (p != 0);
    exp_done = 1'b0;
    if (p == 0) begin
      exp_rd = !rst && tx_enable && (mrd[i] < fwr[i]);
    end else if (p >= 2) begin
      k = p - 2;
      b = k / c;
      if (b == 0)      exp_tx = 1'b0;
      else if (b <= w) exp_tx = mword[i][b-1];
      exp_done = (p == 1 + (w + 2) * c);
      if ((k % c) == (c / 2) && b >= 1 && b <= w) rxw[i][b-1] = got_tx;
    end
    chk((i == 0) ? "rd_en_0" : "rd_en_1", 32'(got_rd), 32'(exp_rd));
    chk((i == 0) ? "tx_0" : "tx_1", 32'(got_tx), 32'(exp_tx));
    chk((i == 0) ? "busy_0" : "busy_1", 32'(got_busy), 32'(exp_busy));
    chk((i == 0) ? "done_0" : "done_1", 32'(got_done), 32'(exp_done));
    if (rst) begin
      phase[i] = 0;
    end else if (p == 0) begin
      if (exp_rd) begin
        mword[i] = fmem[i][mrd[i]];
        mrd[i]   = mrd[i] + 1;
        rxw[i]   = 8'h00;
        phase[i] = 1;
      end
    end else if (exp_done) begin
      chk((i == 0) ? "rx_word_0" : "rx_word_1", 32'(rxw[i]), 32'(mword[i]));
      $display("inst%0d frame word=%02h rx=%02h @%0t", i, mword[i], rxw[i], $time);
      phase[i] = 0;
    end else begin
      phase[i] = p + 1;
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      model_step(0);
      model_step(1);
    end
  end

  task automatic cyc(int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic push(int i, logic [7:0] w);
    fmem[i][fwr[i]] = (i == 0) ? w : (w & 8'h1f);
    fwr[i] = fwr[i] + 1;
  endtask

  initial begin
    int base_p, base_d;
    rst = 1'b1;
    tx_enable = 1'b1;
    cyc(2);
    chk_on = 1'b1;
    chk("rst_tx", 32'(tx0), 32'd1);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_rd_en", 32'(rd0), 32'd0);

    // Empty FIFO: nothing happens.
    rst = 1'b0;
    cyc(100);
    chk("idle_pops", 32'(pops[0]), 32'd0);

    // Single word.
    push(0, 8'hA5);
    cyc(50);
    chk("a5_pops", 32'(pops[0]), 32'd1);
    chk("a5_dones", 32'(dones[0]), 32'd1);

    // Back-to-back pair.
    push(0, 8'h00);
    push(0, 8'hFF);
    cyc(100);
    chk("pair_pops", 32'(pops[0]), 32'd3);
    chk("pair_dones", 32'(dones[0]), 32'd3);

    // tx_enable gating and mid-frame drop.
    tx_enable = 1'b0;
    for (int j = 0; j < 3; j++) push(0, 8'($urandom));
    cyc(20);
    chk("gated_pops", 32'(pops[0]), 32'd3);
    tx_enable = 1'b1;
    cyc(52);
    tx_enable = 1'b0;
    cyc(100);
    chk("drop_pops", 32'(pops[0]), 32'd5);
    chk("drop_left", 32'(fwr[0] - frd[0]), 32'd1);
    tx_enable = 1'b1;
    cyc(50);

    // Reset in the middle of a frame.
    base_d = dones[0];
    push(0, 8'($urandom));
    cyc(12);
    rst = 1'b1;
    cyc(1);
    chk("midrst_tx", 32'(tx0), 32'd1);
    chk("midrst_busy", 32'(busy0), 32'd0);
    rst = 1'b0;
    push(0, 8'h3C);
    cyc(50);
    chk("midrst_dones", 32'(dones[0] - base_d), 32'd1);

    // Narrow instance: 5 bits, 2 clks per bit.
    base_p = pops[1];
    push(1, 8'h13);
    cyc(30);
    chk("w5_pops", 32'(pops[1] - base_p), 32'd1);

    // Randomised traffic on both instances.
    for (int j = 0; j < 40; j++) begin
      if ($urandom_range(0, 1) == 1) push($urandom_range(0, 1), 8'($urandom));
      tx_enable = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
      end
      cyc($urandom_range(0, 20));
    end
    tx_enable = 1'b1;
    cyc(1800);
    chk("drain_0", 32'(fwr[0] - frd[0]), 32'd0);
    chk("drain_1", 32'(fwr[1] - frd[1]), 32'd0);
    chk("model_sync_0", 32'(mrd[0]), 32'(frd[0]));
    chk("model_sync_1", 32'(mrd[1]), 32'(frd[1]));

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
